// File: rtl/noc_pkg.sv
// Shared definitions for the PE network interface: flit layout and skid buffer states.
package noc_pkg;

    localparam int unsigned FLIT_W    = 32;
    localparam int unsigned DEST_MSB  = 31;
    localparam int unsigned DEST_LSB  = 24;
    localparam int unsigned DEST_W    = DEST_MSB - DEST_LSB + 1;
    localparam int unsigned PAYLOAD_W = 24;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    function automatic logic [DEST_W-1:0] flit_dest(input flit_t f);
        return f[DEST_MSB:DEST_LSB];
    endfunction

endpackage

// File: rtl/noc_skid_buffer.sv
// Two-entry fully registered skid buffer: FIFO order, ready derived from registered occupancy.
module noc_skid_buffer
    import noc_pkg::*;
#(
    parameter int unsigned Width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [Width-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [Width-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    skid_state_t      state;
    logic [Width-1:0] tail;
    logic             push;
    logic             pop;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // out_data is the head entry; valid/ready are registered alongside state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= EMPTY;
            out_data  <= '0;
            tail      <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    in_ready <= 1'b1;
                    if (push) begin
                        out_data  <= in_data;
                        out_valid <= 1'b1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    case ({push, pop})
                        2'b10: begin
                            tail     <= in_data;
                            in_ready <= 1'b0;
                            state    <= FULL;
                        end
                        2'b01: begin
                            out_valid <= 1'b0;
                            state     <= EMPTY;
                        end
                        2'b11: out_data <= in_data;
                        default: ;
                    endcase
                end
                FULL: begin
                    if (pop) begin
                        out_data <= tail;
                        in_ready <= 1'b1;
                        state    <= ONE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b0;
                    state     <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/noc_pe_interface.sv
// PE <-> switch leaf network interface; define NOC_MISROUTE_CNT_EN to enable the
// saturating misrouted-flit counter on o_misroute_cnt (otherwise tied to zero).
module noc_pe_interface
    import noc_pkg::*;
#(
    parameter int unsigned             DataWidth = 32,
    parameter int unsigned             AddrWidth = 8,
    parameter logic [AddrWidth-1:0]    MyAddr    = '0
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic [DataWidth-AddrWidth-1:0] i_pe_data,
    input  logic [AddrWidth-1:0]           i_pe_dest,
    input  logic                           i_pe_valid,
    output logic                           o_pe_ready,
    output logic [DataWidth-1:0]           o_data,
    output logic                           o_data_valid,
    input  logic                           i_data_ready,
    input  logic [DataWidth-1:0]           i_data,
    input  logic                           i_data_valid,
    output logic                           o_data_ready,
    output logic [DataWidth-AddrWidth-1:0] o_pe_rx_data,
    output logic                           o_pe_rx_valid,
    input  logic                           i_pe_rx_ready,
    output logic [15:0]                    o_misroute_cnt
);

    logic rx_match;
    logic rx_push_valid;

    noc_skid_buffer #(.Width(DataWidth)) u_tx_buf (
        .clk       (i_clk),
        .reset     (i_reset),
        .in_data   ({i_pe_dest, i_pe_data}),
        .in_valid  (i_pe_valid),
        .in_ready  (o_pe_ready),
        .out_data  (o_data),
        .out_valid (o_data_valid),
        .out_ready (i_data_ready)
    );

    // Misrouted flits are still handshaken via o_data_ready but never enter the buffer.
    assign rx_match      = (flit_dest(i_data) == MyAddr);
    assign rx_push_valid = i_data_valid & rx_match;

    noc_skid_buffer #(.Width(DataWidth-AddrWidth)) u_rx_buf (
        .clk       (i_clk),
        .reset     (i_reset),
        .in_data   (i_data[DataWidth-AddrWidth-1:0]),
        .in_valid  (rx_push_valid),
        .in_ready  (o_data_ready),
        .out_data  (o_pe_rx_data),
        .out_valid (o_pe_rx_valid),
        .out_ready (i_pe_rx_ready)
    );

`ifdef NOC_MISROUTE_CNT_EN
    logic rx_drop;
    assign rx_drop = i_data_valid & o_data_ready & ~rx_match;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_misroute_cnt <= '0;
        end else if (rx_drop && (o_misroute_cnt != '1)) begin
            o_misroute_cnt <= o_misroute_cnt + 16'd1;
        end
    end
`else
    assign o_misroute_cnt = '0;
`endif

endmodule

// File: doc/noc_pe_interface.md
# noc_pe_interface

Network interface between one processing element (PE) and a leaf port of the switch tree. TX path packs 24-bit PE payloads with an 8-bit destination into 32-bit flits (destination in bits [31:24], the field every switch routes on) and presents them on a valid/ready stream into the switch input FIFO. RX path accepts flits from the switch output, checks the destination against the PE's own address, strips the header and delivers payloads to the PE. Both directions are fully registered so the switch-to-PE boundary carries no combinational ready paths.

## Interface
- DataWidth, 32, flit width; only 32 is supported.
- AddrWidth, 8, destination field width, flit bits [31:24].
- MyAddr, 0, this PE's network address; RX accepts only flits with destination == MyAddr.
- i_clk  in  1  single clock for the whole block.
- i_reset  in  1  reset; one clock; reset is synchronous and active-high.
- i_pe_data  in  24  TX payload from PE.
- i_pe_dest  in  8  TX destination address.
- i_pe_valid  in  1  TX request from PE.
- o_pe_ready  out  1  TX accept; registered.
- o_data  out  32  flit to switch, {dest, payload}.
- o_data_valid  out  1  flit valid to switch.
- i_data_ready  in  1  switch FIFO ready.
- i_data  in  32  flit from switch.
- i_data_valid  in  1  flit valid from switch.
- o_data_ready  out  1  RX accept; registered.
- o_pe_rx_data  out  24  delivered payload, flit bits [23:0].
- o_pe_rx_valid  out  1  delivered payload valid.
- i_pe_rx_ready  in  1  PE ready for RX payload.
- o_misroute_cnt  out  16  count of dropped misrouted flits (NOC_MISROUTE_CNT_EN only).

## Operation
- Transfer on any stream occurs on a rising edge where valid and ready are both 1.
- TX: accepted {i_pe_dest, i_pe_data} enters a 2-entry skid buffer; head drives o_data/o_data_valid. No reformatting beyond concatenation; dest == MyAddr is forwarded unchanged.
- RX: accepted flit with i_data[31:24] == MyAddr enters a 2-entry skid buffer; head drives o_pe_rx_data/o_pe_rx_valid. Flit with any other destination is accepted (o_data_ready still governs) and discarded; never reaches the PE.
- Skid buffer states: EMPTY (0 entries), ONE (1), FULL (2). EMPTY->ONE on push; ONE->FULL on push without pop; ONE->EMPTY on pop without push; ONE stays on push+pop; FULL->ONE on pop. Push in FULL is impossible (ready low). Order strictly FIFO.
- Upstream ready = registered (state != FULL).
- Valid, once asserted, holds with stable data until transfer; downstream ready may toggle freely.
- Dropped flit never occupies a buffer slot; it is consumed the same cycle regardless of buffer state provided o_data_ready is 1.

## Timing
- Reset (i_reset high at edge): buffers EMPTY; o_data_valid=0, o_pe_rx_valid=0, o_pe_ready=0, o_data_ready=0, o_misroute_cnt=0. Ready outputs go 1 on the first cycle after reset deasserts.
- Reset mid-operation: buffered flits are lost, counter cleared; no partial flit emitted.
- Latency: accept at edge N -> valid at output in cycle N+1 (one cycle, either path).
- Throughput: 1 flit/cycle sustained when downstream ready is held high.
- Downstream stall: up to 2 flits absorbed; upstream ready drops in the cycle after the second push.
- Simultaneous push and pop in ONE: occupancy stays 1, new data becomes head the next cycle after old head leaves.

## Configuration
- NOC_MISROUTE_CNT_EN defined: o_misroute_cnt increments by 1 per dropped flit, saturates at 16'hFFFF, cleared only by reset.
- Undefined: counter logic removed, o_misroute_cnt tied to 0; drop behaviour unchanged.

## Structure
- Shared package noc_pkg: FLIT_W=32, DEST_MSB=31, DEST_LSB=24, PAYLOAD_W=24, flit typedef, skid state enum (EMPTY/ONE/FULL).
- Sub-module noc_skid_buffer (parameterised width), instantiated once for TX (32 bits) and once for RX (24 bits).

## Test plan
- TX stream: MyAddr=3, push dest=5 payloads 0x000001..0x000008 back-to-back, i_data_ready=1 -> o_data 0x05000001..0x05000008, one per cycle, first valid one cycle after first accept.
- TX backpressure: i_data_ready=0, push 3 flits -> 2 accepted, o_pe_ready=0 from cycle after second; release ready -> both emerge in order, third accepted.
- RX delivery/drop: inject 0x03ABCDEF, 0x07123456, 0x03000042 -> PE sees 0xABCDEF then 0x000042; o_misroute_cnt=1 (macro defined), 0 (undefined).
- RX saturation: with macro, inject 65540 misrouted flits -> o_misroute_cnt=0xFFFF, no PE valid.
- Reset mid-operation: TX FULL and RX ONE, assert i_reset one cycle -> all valids 0, counter 0, readies 0 during reset and 1 after; no stale flit delivered.
- Random ready toggling on both downstreams with random traffic -> scoreboard order and content match, no valid drop before transfer.
